// File: rtl/game_turn_ctrl.sv
// rtl/game_turn_ctrl.sv - two-player card turn controller with turn timeout and round scoring
module game_turn_ctrl #(
    parameter int ROUNDS  = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       p1_btn,
    input  logic       p2_btn,
    output logic [2:0] state,
    output logic [3:0] p1_card,
    output logic [3:0] p2_card,
    output logic [1:0] winner,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       game_over,
    output logic       timeout_pulse
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_DEAL_P1 = 3'b001,
        S_DEAL_P2 = 3'b010,
        S_P1_TURN = 3'b011,
        S_P2_TURN = 3'b100,
        S_COMPARE = 3'b101,
        S_DONE    = 3'b110
    } state_e;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  ROUND_LAST = 4'(ROUNDS);

    logic [3:0]  lfsr;
    logic [3:0]  round_cnt;
    logic [3:0]  round_nxt;
    logic [15:0] timer;
    logic        turn_expired;

    assign turn_expired = (timer == TIMER_LAST);
    assign round_nxt    = round_cnt + 4'd1;
    assign game_over    = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            lfsr          <= 4'b0001;
            p1_card       <= 4'd0;
            p2_card       <= 4'd0;
            winner        <= 2'b00;
            p1_score      <= 4'd0;
            p2_score      <= 4'd0;
            round_cnt     <= 4'd0;
            timer         <= 16'd0;
            timeout_pulse <= 1'b0;
        end else begin
            lfsr          <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            // Timer only survives a cycle spent waiting in a turn state.
            timer         <= 16'd0;
            timeout_pulse <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_DEAL_P1;
                        winner    <= 2'b00;
                        p1_score  <= 4'd0;
                        p2_score  <= 4'd0;
                        round_cnt <= 4'd0;
                    end
                end
                S_DEAL_P1: begin
                    p1_card <= lfsr;
                    state   <= S_DEAL_P2;
                end
                S_DEAL_P2: begin
                    p2_card <= lfsr;
                    state   <= S_P1_TURN;
                end
                S_P1_TURN: begin
                    if (p1_btn) begin
                        state <= S_P2_TURN;
                    end else if (turn_expired) begin
                        state         <= S_P2_TURN;
                        timeout_pulse <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_P2_TURN: begin
                    if (p2_btn) begin
                        state <= S_COMPARE;
                    end else if (turn_expired) begin
                        state         <= S_COMPARE;
                        timeout_pulse <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_COMPARE: begin
                    if (p1_card > p2_card) begin
                        winner <= 2'b01;
                        if (p1_score != 4'hf) p1_score <= p1_score + 4'd1;
                    end else if (p1_card < p2_card) begin
                        winner <= 2'b10;
                        if (p2_score != 4'hf) p2_score <= p2_score + 4'd1;
                    end else begin
                        winner <= 2'b11;
                    end
                    round_cnt <= round_nxt;
                    state     <= (round_nxt == ROUND_LAST) ? S_DONE : S_DEAL_P1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
